// File: rtl/motion_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : motion_pkg
// Description : Shared types and constants for the motion command sequencer:
//               sequencer states, queued command layout, axis count helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package motion_pkg;

    localparam int         NUM_MOTORS = 6;
    localparam logic [5:0] ALL_CAL    = 6'h3F;
    localparam int         CMD_W      = 14;

    typedef enum logic [2:0] {
        ST_CAL_REQ    = 3'd0,
        ST_CAL_WAIT   = 3'd1,
        ST_IDLE       = 3'd2,
        ST_LOAD       = 3'd3,
        ST_START_WAIT = 3'd4,
        ST_RUN        = 3'd5,
        ST_PARK       = 3'd6
    } seq_state_t;

    typedef struct packed {
        logic [2:0] motor;
        logic [9:0] pulses;
        logic       dir;
    } motion_cmd_t;

    // A command is usable only for an existing axis and a non-zero move.
    function automatic logic cmd_is_legal(input motion_cmd_t c);
        return (c.motor < 3'(NUM_MOTORS)) && (c.pulses != 10'd0);
    endfunction

    // Axis index to one-hot select; out-of-range indices give all zeros.
    function automatic logic [NUM_MOTORS-1:0] motor_onehot(input logic [2:0] m);
        logic [NUM_MOTORS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            oh[i] = (m == 3'(i));
        end
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/motion_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : motion_sequencer_if
// Description : Host-side move command channel (valid/ready handshake plus
//               motor index, pulse count and direction).
// Revision    : 1.0 - initial release
// ============================================================================
interface motion_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_motor;
    logic [9:0] cmd_pulses;
    logic       cmd_dir;

    modport master (output cmd_valid, cmd_motor, cmd_pulses, cmd_dir,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, cmd_motor, cmd_pulses, cmd_dir,
                    output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/cmd_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cmd_fifo
// Description : Synchronous show-ahead FIFO for queued move commands. Pointers
//               carry one wrap bit so full and empty are told apart directly.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign rdata     = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer advance; reset empties the queue.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge sysclk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/motion_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : motion_sequencer
// Description : Command scheduler in front of the six-axis step-pulse
//               generator. Queues host moves, runs origin calibration, then
//               feeds one move at a time to the generator with parking gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module motion_sequencer
    import motion_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int PARK_CYCLES   = 4,
    parameter int START_TIMEOUT = 255,
    parameter int INIT_PULSE    = 2
) (
    input  logic                    sysclk,
    input  logic                    rst_n,
    motion_sequencer_if.slave       host,
    input  logic                    recal,
    output logic                    pg_init,
    output logic [NUM_MOTORS-1:0]   pg_motor,
    output logic [9:0]              pg_pulse_num,
    output logic [NUM_MOTORS-1:0]   pg_dir,
    input  logic                    pg_busy,
    input  logic [NUM_MOTORS-1:0]   pg_init_flag,
    output logic                    calibrated,
    output logic [15:0]             moves_done,
    output logic                    err_timeout,
    output logic                    err_illegal
);
    // One shared cycle counter serves CAL_REQ, START_WAIT and PARK.
    localparam int CNT_MAX =
        (START_TIMEOUT > PARK_CYCLES) ?
            ((START_TIMEOUT > INIT_PULSE) ? START_TIMEOUT : INIT_PULSE) :
            ((PARK_CYCLES   > INIT_PULSE) ? PARK_CYCLES   : INIT_PULSE);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_recal_pend;
    logic              r_ready_en;
    logic              r_init_q;
    motion_cmd_t       r_cmd;

    motion_cmd_t       w_host_cmd;
    motion_cmd_t       w_fifo_head;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_recal_go;
    logic              w_enter_cal;
    logic              w_timeout;
    logic              w_move_done;
    logic [NUM_MOTORS-1:0] w_cmd_oh;

    // Ready comes only from registered state, never from this cycle's pop.
    assign host.cmd_ready = r_ready_en && !w_full;
    assign w_host_cmd     = {host.cmd_motor, host.cmd_pulses, host.cmd_dir};
    assign w_accept       = host.cmd_valid && host.cmd_ready;
    assign w_push         = w_accept && cmd_is_legal(w_host_cmd);
    assign w_recal_go     = r_recal_pend || recal;
    assign w_enter_cal    = (w_state_nxt == ST_CAL_REQ) && (r_state != ST_CAL_REQ);
    assign w_cmd_oh       = motor_onehot(r_cmd.motor);

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .push   (w_push),
        .wdata  (w_host_cmd),
        .pop    (w_pop),
        .rdata  (w_fifo_head),
        .full   (w_full),
        .empty  (w_empty)
    );

    // State register.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_CAL_REQ;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode plus single-cycle event strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_timeout   = 1'b0;
        w_move_done = 1'b0;
        case (r_state)
            ST_CAL_REQ: begin
                if (r_cnt == CNT_W'(INIT_PULSE - 1)) w_state_nxt = ST_CAL_WAIT;
            end
            ST_CAL_WAIT: begin
                // Flags from a previous calibration are ignored until INIT has
                // been low for a full cycle.
                if ((pg_init_flag == ALL_CAL) && !pg_init && !r_init_q)
                    w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_recal_go) begin
                    w_state_nxt = ST_CAL_REQ;
                end else if (!w_empty) begin
                    w_state_nxt = ST_LOAD;
                    w_pop       = 1'b1;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_START_WAIT;
            end
            ST_START_WAIT: begin
                if (pg_busy) begin
                    w_state_nxt = ST_RUN;
                end else if (r_cnt == CNT_W'(START_TIMEOUT)) begin
                    w_state_nxt = ST_PARK;
                    w_timeout   = 1'b1;
                end
            end
            ST_RUN: begin
                if (!pg_busy) begin
                    w_state_nxt = ST_PARK;
                    w_move_done = 1'b1;
                end
            end
            ST_PARK: begin
                if (r_cnt == CNT_W'(PARK_CYCLES - 1))
                    w_state_nxt = w_recal_go ? ST_CAL_REQ : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_CAL_REQ;
            end
        endcase
    end

    // Per-state cycle counter, cleared on every state change, saturating.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n)                        r_cnt <= '0;
        else if (w_state_nxt != r_state)   r_cnt <= '0;
        else if (r_cnt != {CNT_W{1'b1}})   r_cnt <= r_cnt + 1'b1;
    end

    // Remember a recalibration request until an IDLE or PARK exit honours it.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n)           r_recal_pend <= 1'b0;
        else if (w_enter_cal) r_recal_pend <= 1'b0;
        else if (recal)       r_recal_pend <= 1'b1;
    end

    // Capture the FIFO head as it is popped; decoded during LOAD.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n)     r_cmd <= '0;
        else if (w_pop) r_cmd <= w_fifo_head;
    end

    // Generator move inputs: loaded in LOAD, held through START_WAIT/RUN,
    // zero everywhere else so repeated moves still look like a new request.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            pg_motor     <= '0;
            pg_pulse_num <= '0;
            pg_dir       <= '0;
        end else if (r_state == ST_LOAD) begin
            pg_motor     <= w_cmd_oh;
            pg_pulse_num <= r_cmd.pulses;
            pg_dir       <= r_cmd.dir ? w_cmd_oh : '0;
        end else if ((w_state_nxt != ST_START_WAIT) && (w_state_nxt != ST_RUN)) begin
            pg_motor     <= '0;
            pg_pulse_num <= '0;
            pg_dir       <= '0;
        end
    end

    // INIT is high for exactly the cycles following each CAL_REQ cycle.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            pg_init  <= 1'b0;
            r_init_q <= 1'b0;
        end else begin
            pg_init  <= (r_state == ST_CAL_REQ);
            r_init_q <= pg_init;
        end
    end

    // Host-visible status and the post-reset ready enable.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            calibrated  <= 1'b0;
            err_timeout <= 1'b0;
            err_illegal <= 1'b0;
            moves_done  <= '0;
            r_ready_en  <= 1'b0;
        end else begin
            r_ready_en  <= 1'b1;
            err_illegal <= w_accept && !cmd_is_legal(w_host_cmd);
            if (w_enter_cal)
                calibrated <= 1'b0;
            else if ((r_state == ST_CAL_WAIT) && (w_state_nxt == ST_IDLE))
                calibrated <= 1'b1;
            if (w_enter_cal)    err_timeout <= 1'b0;
            else if (w_timeout) err_timeout <= 1'b1;
            if (w_move_done)    moves_done  <= moves_done + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_motion_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_motion_sequencer
// Description : Directed bench for motion_sequencer with a behavioural
//               step-pulse generator and a scoreboard of expected moves.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motion_sequencer;
    import motion_pkg::*;

    localparam int PARK_CYCLES   = 4;
    localparam int INIT_PULSE    = 2;
    localparam int START_TIMEOUT = 255;

    typedef struct packed {
        logic [5:0] motor;
        logic [9:0] pulses;
        logic [5:0] dir;
    } exp_t;

    logic        sysclk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        recal  = 1'b0;
    logic        pg_busy;
    logic [5:0]  pg_init_flag = 6'h00;
    logic        pg_init;
    logic [5:0]  pg_motor;
    logic [9:0]  pg_pulse_num;
    logic [5:0]  pg_dir;
    logic        calibrated;
    logic [15:0] moves_done;
    logic        err_timeout;
    logic        err_illegal;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_windows = 0;
    exp_t exp_q[$];
    exp_t cur;
    bit   busy_q = 1'b0;
    bit   gen_en = 1'b0;
    int   busy_len = 10;
    int   g_st = 0;
    int   g_cnt = 0;

    motion_sequencer_if host();

    motion_sequencer #(
        .FIFO_DEPTH    (4),
        .PARK_CYCLES   (PARK_CYCLES),
        .START_TIMEOUT (START_TIMEOUT),
        .INIT_PULSE    (INIT_PULSE)
    ) dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .host         (host),
        .recal        (recal),
        .pg_init      (pg_init),
        .pg_motor     (pg_motor),
        .pg_pulse_num (pg_pulse_num),
        .pg_dir       (pg_dir),
        .pg_busy      (pg_busy),
        .pg_init_flag (pg_init_flag),
        .calibrated   (calibrated),
        .moves_done   (moves_done),
        .err_timeout  (err_timeout),
        .err_illegal  (err_illegal)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Generator model: a non-zero PulseNum starts a move, Busy rises two
    // cycles later, stays high busy_len cycles, then re-arms once parked.
    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            g_st    <= 0;
            g_cnt   <= 0;
            pg_busy <= 1'b0;
        end else begin
            case (g_st)
                0: if (gen_en && pg_pulse_num != 10'd0) begin g_st <= 1; g_cnt <= 2; end
                1: if (g_cnt == 1) begin pg_busy <= 1'b1; g_cnt <= busy_len; g_st <= 2; end
                   else g_cnt <= g_cnt - 1;
                2: if (g_cnt == 1) begin pg_busy <= 1'b0; g_st <= 3; end
                   else g_cnt <= g_cnt - 1;
                default: if (pg_pulse_num == 10'd0) g_st <= 0;
            endcase
        end
    end

    // Scoreboard: each Busy window consumes one expected move, whose values
    // must be present at Busy rise and stay unchanged while Busy is high.
    always @(negedge sysclk) begin
        if (pg_busy && !busy_q) begin
            chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            chk("move_motor", 32'(pg_motor), 32'(cur.motor));
            chk("move_pulses", 32'(pg_pulse_num), 32'(cur.pulses));
            chk("move_dir", 32'(pg_dir), 32'(cur.dir));
            n_windows++;
        end else if (pg_busy) begin
            chk("move_hold", 32'({pg_motor, pg_pulse_num, pg_dir}), 32'(cur));
        end
        busy_q = pg_busy;
    end

    task automatic drive_cmd(input logic [2:0] m, input logic [9:0] p, input logic d);
        host.cmd_valid  = 1'b1;
        host.cmd_motor  = m;
        host.cmd_pulses = p;
        host.cmd_dir    = d;
    endtask

    task automatic complete_cmd(input bit expect_run, input int bound);
        int   waited;
        bit   legal;
        exp_t e;
        waited = 0;
        legal  = (host.cmd_motor <= 3'd5) && (host.cmd_pulses != 10'd0);
        while (!host.cmd_ready && waited < bound) begin
            @(negedge sysclk);
            waited++;
        end
        chk("handshake_ready", 32'(host.cmd_ready), 32'd1);
        if (!host.cmd_ready) begin
            host.cmd_valid = 1'b0;
            return;
        end
        @(posedge sysclk);
        #1;
        host.cmd_valid = 1'b0;
        if (legal && expect_run) begin
            e.motor  = 6'd1 << host.cmd_motor;
            e.pulses = host.cmd_pulses;
            e.dir    = host.cmd_dir ? e.motor : 6'd0;
            exp_q.push_back(e);
        end
        @(negedge sysclk);
        chk("err_illegal_pulse", 32'(err_illegal), 32'(!legal));
        @(negedge sysclk);
        chk("err_illegal_clear", 32'(err_illegal), 32'd0);
    endtask

    task automatic push_cmd(input logic [2:0] m, input logic [9:0] p, input logic d,
                            input bit expect_run);
        drive_cmd(m, p, d);
        complete_cmd(expect_run, 400);
    endtask

    task automatic wait_moves(input int target, input int bound);
        int n;
        n = 0;
        while (32'(moves_done) != target && n < bound) begin
            @(negedge sysclk);
            n++;
        end
        chk("moves_done", 32'(moves_done), 32'(target));
    endtask

    // Waits for INIT to rise, drops the axis flags as a generator would,
    // and measures how long INIT stays high.
    task automatic observe_init_pulse();
        int n;
        n = 0;
        while (!pg_init && n < 20) begin
            @(negedge sysclk);
            n++;
        end
        chk("init_seen", 32'(pg_init), 32'd1);
        pg_init_flag = 6'h00;
        n = 0;
        while (pg_init && n < 20) begin
            @(negedge sysclk);
            n++;
        end
        chk("init_len", 32'(n), 32'(INIT_PULSE));
    endtask

    task automatic finish_calibration();
        int n;
        repeat (50) @(negedge sysclk);
        chk("cal_pending", 32'(calibrated), 32'd0);
        pg_init_flag = ALL_CAL;
        n = 0;
        while (!calibrated && n < 20) begin
            @(negedge sysclk);
            n++;
        end
        chk("calibrated", 32'(calibrated), 32'd1);
    endtask

    initial begin
        int gap;
        int t;
        host.cmd_valid  = 1'b0;
        host.cmd_motor  = 3'd0;
        host.cmd_pulses = 10'd0;
        host.cmd_dir    = 1'b0;

        // Reset values
        repeat (3) @(negedge sysclk);
        chk("rst_pg_init", 32'(pg_init), 32'd0);
        chk("rst_pg_motor", 32'(pg_motor), 32'd0);
        chk("rst_pg_pulse_num", 32'(pg_pulse_num), 32'd0);
        chk("rst_pg_dir", 32'(pg_dir), 32'd0);
        chk("rst_calibrated", 32'(calibrated), 32'd0);
        chk("rst_moves_done", 32'(moves_done), 32'd0);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
        chk("rst_err_illegal", 32'(err_illegal), 32'd0);
        chk("rst_cmd_ready", 32'(host.cmd_ready), 32'd0);
        rst_n = 1'b1;

        // Power-up calibration
        observe_init_pulse();
        finish_calibration();
        chk("ready_after_cal", 32'(host.cmd_ready), 32'd1);

        // Single move with a long Busy window, then parked outputs
        gen_en   = 1'b1;
        busy_len = 200;
        push_cmd(3'd2, 10'd100, 1'b1, 1'b1);
        wait_moves(1, 600);
        for (int i = 0; i < PARK_CYCLES; i++) begin
            chk("park_zero", 32'({pg_motor, pg_pulse_num, pg_dir}), 32'd0);
            @(negedge sysclk);
        end
        chk("windows_1", 32'(n_windows), 32'd1);

        // Identical back-to-back moves must both reach the generator
        busy_len = 10;
        push_cmd(3'd4, 10'd37, 1'b0, 1'b1);
        push_cmd(3'd4, 10'd37, 1'b0, 1'b1);
        wait_moves(2, 200);
        gap = 0;
        while (pg_pulse_num == 10'd0 && gap < 50) begin
            @(negedge sysclk);
            gap++;
        end
        chk("park_gap_min", 32'(gap >= PARK_CYCLES), 32'd1);
        chk("park_gap_max", 32'(gap <= PARK_CYCLES + 3), 32'd1);
        wait_moves(3, 200);
        chk("windows_3", 32'(n_windows), 32'd3);

        // Hold calibration, fill FIFO around two illegal commands
        @(negedge sysclk);
        recal = 1'b1;
        @(negedge sysclk);
        recal = 1'b0;
        observe_init_pulse();
        chk("recal_uncal", 32'(calibrated), 32'd0);
        busy_len = 20;
        push_cmd(3'd0, 10'd1,    1'b0, 1'b1);
        push_cmd(3'd1, 10'd2,    1'b1, 1'b1);
        push_cmd(3'd5, 10'd1023, 1'b1, 1'b1);
        push_cmd(3'd7, 10'd50,   1'b1, 1'b1);
        push_cmd(3'd3, 10'd0,    1'b0, 1'b1);
        chk("ready_after_illegal", 32'(host.cmd_ready), 32'd1);
        push_cmd(3'd3, 10'd512,  1'b0, 1'b1);
        chk("fifo_full", 32'(host.cmd_ready), 32'd0);
        drive_cmd(3'd2, 10'd7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("fifth_stalls", 32'(host.cmd_ready), 32'd0);
            @(negedge sysclk);
        end
        pg_init_flag = ALL_CAL;
        complete_cmd(1'b1, 100);
        wait_moves(8, 1000);
        chk("windows_8", 32'(n_windows), 32'd8);

        // Start timeout: generator never answers
        gen_en = 1'b0;
        push_cmd(3'd0, 10'd5, 1'b0, 1'b0);
        t = 0;
        while (pg_motor == 6'd0 && t < 20) begin
            @(negedge sysclk);
            t++;
        end
        chk("timeout_load", 32'(pg_motor), 32'h01);
        t = 0;
        while (!err_timeout && t < 400) begin
            @(negedge sysclk);
            t++;
        end
        chk("err_timeout_set", 32'(err_timeout), 32'd1);
        chk("timeout_window", 32'(t >= START_TIMEOUT - 1 && t <= START_TIMEOUT + 3), 32'd1);
        chk("timeout_parked", 32'({pg_motor, pg_pulse_num, pg_dir}), 32'd0);
        chk("timeout_no_count", 32'(moves_done), 32'd8);
        repeat (10) @(negedge sysclk);
        gen_en = 1'b1;
        push_cmd(3'd1, 10'd3, 1'b1, 1'b1);
        wait_moves(9, 200);
        chk("err_timeout_sticky", 32'(err_timeout), 32'd1);

        // Recal during RUN waits for the move, then clears the error
        busy_len = 30;
        push_cmd(3'd0, 10'd9, 1'b1, 1'b1);
        t = 0;
        while (!pg_busy && t < 20) begin
            @(negedge sysclk);
            t++;
        end
        recal = 1'b1;
        @(negedge sysclk);
        recal = 1'b0;
        repeat (3) @(negedge sysclk);
        chk("recal_no_abort_init", 32'(pg_init), 32'd0);
        chk("recal_no_abort_pulses", 32'(pg_pulse_num), 32'd9);
        wait_moves(10, 100);
        observe_init_pulse();
        chk("recal_clears_timeout", 32'(err_timeout), 32'd0);
        chk("recal_uncal_2", 32'(calibrated), 32'd0);
        finish_calibration();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a move
        busy_len = 100;
        push_cmd(3'd5, 10'd200, 1'b1, 1'b1);
        t = 0;
        while (!pg_busy && t < 20) begin
            @(negedge sysclk);
            t++;
        end
        chk("run_started", 32'(pg_busy), 32'd1);
        repeat (5) @(negedge sysclk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_pg_motor", 32'(pg_motor), 32'd0);
        chk("midrun_pg_pulse_num", 32'(pg_pulse_num), 32'd0);
        chk("midrun_pg_dir", 32'(pg_dir), 32'd0);
        chk("midrun_pg_init", 32'(pg_init), 32'd0);
        chk("midrun_moves_done", 32'(moves_done), 32'd0);
        chk("midrun_calibrated", 32'(calibrated), 32'd0);
        chk("midrun_cmd_ready", 32'(host.cmd_ready), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge sysclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no completion expected completion before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/motion_sequencer.md
Name: motion_sequencer

Overview:
Command scheduler in front of the six-axis step-pulse generator. Accepts queued move commands (motor index, pulse count, direction) over a valid/ready handshake and buffers them in a 4-entry FIFO. Runs origin calibration once after reset or on request, then drives one move at a time into the generator, holding its inputs stable until the generator's Busy falls. Reports completion count and timeout errors to the host-side control logic.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
PARK_CYCLES, 4, sysclk cycles pg_pulse_num is held at 0 between moves
START_TIMEOUT, 255, max cycles waiting for pg_busy to rise after load
INIT_PULSE, 2, cycles pg_init is held high

Ports:
sysclk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO not full
cmd_motor  in  3  motor index 0..5 (6,7 illegal)
cmd_pulses  in  10  pulse count, 1..1023 (0 illegal)
cmd_dir  in  1  direction
recal  in  1  single-cycle request to re-run origin calibration
pg_init  out  1  to generator INIT
pg_motor  out  6  to generator Motor (one-hot)
pg_pulse_num  out  10  to generator PulseNum
pg_dir  out  6  to generator DRIn
pg_busy  in  1  generator Busy
pg_init_flag  in  6  generator initFlag
calibrated  out  1  all six axes calibrated and sequencer out of CAL states
moves_done  out  16  completed-move counter, wraps at 65535->0
err_timeout  out  1  sticky; set on start timeout, cleared by recal or reset
err_illegal  out  1  single-cycle pulse when an illegal command is dropped

Behaviour:
- Reset (rst_n=0, async): FIFO empty, state CAL_REQ, pg_init=0, pg_motor=0, pg_pulse_num=0, pg_dir=0, calibrated=0, moves_done=0, err_timeout=0, err_illegal=0; cmd_ready=0 while in reset.
- FIFO push when cmd_valid & cmd_ready; cmd_ready = !full. Illegal command (motor>5 or pulses==0) is accepted but not written; err_illegal=1 next cycle. Simultaneous push and pop on full FIFO: pop first, push accepted, cmd_ready must be 1 that cycle only if not full before pop (no combinational ready-from-pop path).
- FSM:
  CAL_REQ: pg_init=1 for INIT_PULSE cycles -> CAL_WAIT.
  CAL_WAIT: pg_motor/pg_pulse_num/pg_dir=0; wait pg_init_flag==6'h3F -> IDLE, calibrated=1. No timeout (limit switches are mechanical).
  IDLE: FIFO non-empty -> LOAD (pop).
  LOAD: one cycle; register pg_motor=1<<motor, pg_pulse_num=pulses, pg_dir = dir ? pg_motor : 0 -> START_WAIT, timer=0.
  START_WAIT: pg_busy=1 -> RUN; timer==START_TIMEOUT -> err_timeout=1, PARK.
  RUN: hold outputs; pg_busy=0 -> moves_done+=1, PARK.
  PARK: pg_motor=0, pg_pulse_num=0, pg_dir=0 for PARK_CYCLES (forces generator parameter change so identical consecutive commands retrigger) -> IDLE.
- recal: sampled in any state; takes effect at next IDLE/PARK exit (never aborts RUN); clears err_timeout, calibrated=0, -> CAL_REQ. FIFO contents retained.
- pg_* outputs are registered, stable for entire START_WAIT/RUN.
- Reset mid-RUN: all outputs to reset values immediately; queued commands lost.

Decomposition:
- Package motion_pkg: state enum, command struct {motor[2:0], pulses[9:0], dir}, NUM_MOTORS=6, ALL_CAL=6'h3F.
- Sub-module cmd_fifo (sync FIFO, sysclk/rst_n, width 14, depth FIFO_DEPTH, full/empty flags).

Test Plan:
- Reset release, pg_init_flag driven to 6'h3F 50 cycles after pg_init -> pg_init high 2 cycles, calibrated=1 after flag, state IDLE.
- Command (motor 2, 100 pulses, dir 1), model Busy for 200 cycles -> pg_motor=6'b000100, pg_pulse_num=100, pg_dir=6'b000100 until Busy falls; moves_done=1; 4 zero cycles follow.
- Two identical commands back-to-back -> two separate Busy windows, moves_done=2.
- Push 5 commands without popping (hold calibration) -> cmd_ready=0 after 4th; 5th stalls until first pop.
- Busy never rises -> err_timeout=1 after 255 cycles in START_WAIT, next command executes; recal clears it and re-runs CAL_REQ.
- Command motor=7 or pulses=0 -> err_illegal one cycle, FIFO count unchanged; rst_n low mid-RUN -> all pg_* 0 asynchronously.
